// File: rtl/alu_sequencer.sv
// Stored-program controller for the 4-bit accumulator/ALU datapath.
// Each instruction runs FETCH -> DECODE -> EXEC; HALT is left only by reset.
module alu_sequencer #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      instr,
   input  logic            c,
   input  logic            z,
   output logic [PC_W-1:0] pc,
   output logic            accu_en,
   output logic            bus1_en,
   output logic            bus2_en,
   output logic [2:0]      Sel,
   output logic [3:0]      oprnd,
   output logic            halted
);

   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_NAND = 4'h4;
   localparam logic [3:0] OP_OUT  = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JC   = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_JNC  = 4'h9;
   localparam logic [3:0] OP_JNZ  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t          state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next;
   logic [7:0]      ir_reg, ir_next;
   logic            c_reg, c_next;
   logic            z_reg, z_next;
   logic            halted_reg, halted_next;

   logic            accu_en_next, bus1_en_next, bus2_en_next;
   logic [2:0]      sel_next;
   logic [3:0]      oprnd_next;
   logic            take_jump;

   logic [3:0]      opcode;
   logic [3:0]      operand;

   assign opcode  = ir_reg[7:4];
   assign operand = ir_reg[3:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= FETCH;
         pc_reg     <= '0;
         ir_reg     <= '0;
         c_reg      <= 1'b0;
         z_reg      <= 1'b0;
         halted_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         ir_reg     <= ir_next;
         c_reg      <= c_next;
         z_reg      <= z_next;
         halted_reg <= halted_next;
      end
   end

   always_comb begin
      take_jump = 1'b0;
      unique case (opcode)
         OP_JMP:  take_jump = 1'b1;
         OP_JC:   take_jump = c_reg;
         OP_JZ:   take_jump = z_reg;
         OP_JNC:  take_jump = ~c_reg;
         OP_JNZ:  take_jump = ~z_reg;
         default: take_jump = 1'b0;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      ir_next      = ir_reg;
      c_next       = c_reg;
      z_next       = z_reg;
      halted_next  = halted_reg;
      accu_en_next = 1'b0;
      bus1_en_next = 1'b0;
      bus2_en_next = 1'b0;
      sel_next     = 3'b000;
      oprnd_next   = 4'h0;

      unique case (state_reg)
         FETCH: begin
            ir_next    = instr;
            state_next = DECODE;
         end
         DECODE: begin
            pc_next    = pc_reg + PC_W'(1);
            state_next = EXEC;
         end
         EXEC: begin
            state_next = FETCH;
            if (opcode >= OP_LDI && opcode <= OP_NAND) begin
               accu_en_next = 1'b1;
               bus1_en_next = 1'b1;
               oprnd_next   = operand;
               c_next       = c;
               z_next       = z;
               unique case (opcode)
                  OP_LDI:  sel_next = 3'b010;
                  OP_ADD:  sel_next = 3'b011;
                  OP_SUB:  sel_next = 3'b001;
                  default: sel_next = 3'b100;
               endcase
            end else if (opcode == OP_OUT) begin
               bus2_en_next = 1'b1;
            end else if (opcode == OP_HALT) begin
               state_next  = HALT;
               halted_next = 1'b1;
            end
            // Page comes from the already-incremented pc, so a jump at the top
            // of memory lands in page 0.
            if (take_jump) begin
               pc_next = {pc_reg[PC_W-1:4], operand};
            end
         end
         default: begin
            state_next = HALT;
         end
      endcase
   end

   assign pc      = pc_reg;
   assign halted  = halted_reg;
   assign accu_en = accu_en_next & ~reset;
   assign bus1_en = bus1_en_next & ~reset;
   assign bus2_en = bus2_en_next & ~reset;
   assign Sel     = reset ? 3'b000 : sel_next;
   assign oprnd   = reset ? 4'h0 : oprnd_next;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: an instruction-level reference model
// predicts every cycle's pc, strobes and halted flag.
module tb_alu_sequencer;
   localparam int PC_W = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            c = 1'b0;
   logic            z = 1'b0;
   logic            rom_mode = 1'b0;
   logic [7:0]      rnd_instr = 8'h00;
   logic [7:0]      rom [256];
   logic [7:0]      instr;
   logic [PC_W-1:0] pc;
   logic            accu_en, bus1_en, bus2_en, halted;
   logic [2:0]      Sel;
   logic [3:0]      oprnd;

   int checks = 0;
   int errors = 0;

   // Instruction-level reference state
   logic [7:0] m_pc;
   logic       m_c, m_z, m_halted;
   logic       rand_flags = 1'b1;
   logic       c_drv = 1'b0, z_drv = 1'b0;

   assign instr = rom_mode ? rom[pc] : rnd_instr;

   alu_sequencer #(.PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .instr(instr), .c(c), .z(z), .pc(pc),
      .accu_en(accu_en), .bus1_en(bus1_en), .bus2_en(bus2_en),
      .Sel(Sel), .oprnd(oprnd), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_flags();
      if (rand_flags) begin
         c = 1'($urandom_range(0, 1));
         z = 1'($urandom_range(0, 1));
      end else begin
         c = c_drv;
         z = z_drv;
      end
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rnd_instr = 8'($urandom);
      tick();
      tick();
      reset = 1'b0;
      m_pc = 8'h00;
      m_c = 1'b0;
      m_z = 1'b0;
      m_halted = 1'b0;
   endtask

   // Runs count instruction slots (3 cycles each, 1 cycle once halted) and
   // compares every cycle against the reference model.
   task automatic run_instrs(input int count, input string tag);
      for (int k = 0; k < count; k++) begin
         logic [7:0]  w;
         logic [3:0]  op, n;
         logic [7:0]  p1;
         logic [10:0] exp_v, obs_v;
         logic [7:0]  exp_pc;
         logic        take;
         if (m_halted) begin
            drive_flags();
            rnd_instr = 8'($urandom);
            checks++;
            obs_v = {accu_en, bus1_en, bus2_en, Sel, oprnd, halted};
            if (obs_v !== 11'b000_000_0000_1 || pc !== m_pc) begin
               errors++;
               $display("FAIL %s halted-idle: got out=%b pc=%02h, want out=%b pc=%02h",
                        tag, obs_v, pc, 11'b000_000_0000_1, m_pc);
            end
            $display("[%0t] %s halted pc=%02h", $time, tag, pc);
            tick();
            continue;
         end
         w  = rom[m_pc];
         op = w[7:4];
         n  = w[3:0];
         p1 = m_pc + 8'd1;
         for (int cyc = 0; cyc < 3; cyc++) begin
            drive_flags();
            exp_v  = 11'b0;
            exp_pc = (cyc == 2) ? p1 : m_pc;
            if (cyc == 2) begin
               case (op)
                  4'h1: exp_v = {1'b1, 1'b1, 1'b0, 3'b010, n, 1'b0};
                  4'h2: exp_v = {1'b1, 1'b1, 1'b0, 3'b011, n, 1'b0};
                  4'h3: exp_v = {1'b1, 1'b1, 1'b0, 3'b001, n, 1'b0};
                  4'h4: exp_v = {1'b1, 1'b1, 1'b0, 3'b100, n, 1'b0};
                  4'h5: exp_v = {1'b0, 1'b0, 1'b1, 3'b000, 4'h0, 1'b0};
                  default: exp_v = 11'b0;
               endcase
            end
            obs_v = {accu_en, bus1_en, bus2_en, Sel, oprnd, halted};
            checks++;
            if (obs_v !== exp_v || pc !== exp_pc) begin
               errors++;
               $display("FAIL %s instr %02h@%02h cycle %0d: got out=%b pc=%02h, want out=%b pc=%02h",
                        tag, w, m_pc, cyc, obs_v, pc, exp_v, exp_pc);
            end
            if (cyc == 2) begin
               take = (op == 4'h6) || (op == 4'h7 && m_c) || (op == 4'h8 && m_z) ||
                      (op == 4'h9 && !m_c) || (op == 4'hA && !m_z);
               if (op >= 4'h1 && op <= 4'h4) begin
                  m_c = c;
                  m_z = z;
               end
               if (op == 4'hF) m_halted = 1'b1;
            end
            tick();
         end
         $display("[%0t] %s pc=%02h instr=%02h", $time, tag, m_pc, w);
         m_pc = take ? {p1[7:4], n} : p1;
      end
   endtask

   task automatic test_reset();
      logic [10:0] obs_v;
      rom_mode = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rnd_instr = 8'($urandom);
         drive_flags();
         tick();
         obs_v = {accu_en, bus1_en, bus2_en, Sel, oprnd, halted};
         checks++;
         if (obs_v !== 11'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got out=%b pc=%02h, want out=0 pc=00", obs_v, pc);
         end
      end
      rom_clear();
      rom_mode = 1'b1;
      reset = 1'b0;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         checks++;
         if (pc !== ((cyc == 3) ? 8'h01 : 8'h00)) begin
            errors++;
            $display("FAIL reset_release cycle %0d: got pc=%02h, want pc=%02h",
                     cyc, pc, (cyc == 3) ? 8'h01 : 8'h00);
         end
         tick();
      end
      $display("[%0t] reset sequence done", $time);
   endtask

   task automatic test_arith();
      rom_clear();
      rom[0] = 8'h11; rom[1] = 8'h23; rom[2] = 8'h50; rom[3] = 8'hF0; rom[4] = 8'h12;
      rand_flags = 1'b1;
      do_reset();
      run_instrs(4, "arith");
      checks++;
      if (halted !== 1'b1 || pc !== 8'h04) begin
         errors++;
         $display("FAIL arith_halt: got halted=%b pc=%02h, want halted=1 pc=04", halted, pc);
      end
      run_instrs(4, "arith_halt");
   endtask

   task automatic test_cond_jump();
      rom_clear();
      rom[0] = 8'h11; rom[1] = 8'h31; rom[2] = 8'h85; rom[5] = 8'hF0;
      rand_flags = 1'b0;
      c_drv = 1'b0;
      z_drv = 1'b1;
      do_reset();
      run_instrs(3, "jz_taken");
      checks++;
      if (pc !== 8'h05) begin
         errors++;
         $display("FAIL jz_taken: got pc=%02h, want pc=05", pc);
      end
      run_instrs(1, "jz_taken");
      z_drv = 1'b0;
      do_reset();
      run_instrs(3, "jz_not_taken");
      checks++;
      if (pc !== 8'h03) begin
         errors++;
         $display("FAIL jz_not_taken: got pc=%02h, want pc=03", pc);
      end
      run_instrs(4, "jz_not_taken");
   endtask

   task automatic test_flag_hold();
      rom_clear();
      rom[0] = 8'h21; rom[1] = 8'h50; rom[2] = 8'h78; rom[8] = 8'hF0;
      rand_flags = 1'b0;
      c_drv = 1'b1;
      z_drv = 1'b0;
      do_reset();
      run_instrs(1, "flag_hold");
      c_drv = 1'b0;
      run_instrs(2, "flag_hold");
      checks++;
      if (pc !== 8'h08) begin
         errors++;
         $display("FAIL flag_hold_jc: got pc=%02h, want pc=08", pc);
      end
      run_instrs(1, "flag_hold");
   endtask

   task automatic test_wrap();
      rom_clear();
      rand_flags = 1'b1;
      do_reset();
      run_instrs(256, "wrap_nop");
      checks++;
      if (pc !== 8'h00) begin
         errors++;
         $display("FAIL wrap_nop: got pc=%02h, want pc=00", pc);
      end
      rom[8'hFF] = 8'h63;
      do_reset();
      run_instrs(256, "wrap_jmp");
      checks++;
      if (pc !== 8'h03) begin
         errors++;
         $display("FAIL wrap_jmp: got pc=%02h, want pc=03", pc);
      end
   endtask

   task automatic test_reset_exec();
      rom_clear();
      rom[0] = 8'h11; rom[1] = 8'h25;
      rand_flags = 1'b1;
      do_reset();
      run_instrs(1, "rst_exec");
      tick();
      tick();
      checks++;
      if (accu_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec_pre: got accu_en=%b, want accu_en=1", accu_en);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({accu_en, bus1_en, Sel, oprnd} !== 9'b0) begin
         errors++;
         $display("FAIL rst_exec_gate: got accu_en=%b bus1_en=%b Sel=%b oprnd=%h, want all 0",
                  accu_en, bus1_en, Sel, oprnd);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_pc = 8'h00;
      m_c = 1'b0;
      m_z = 1'b0;
      m_halted = 1'b0;
      run_instrs(2, "rst_exec_after");
   endtask

   task automatic test_random();
      rom_clear();
      for (int i = 0; i < 256; i++) begin
         rom[i] = 8'($urandom);
         if (rom[i][7:4] == 4'hF) rom[i][7:4] = 4'h0;
      end
      rand_flags = 1'b1;
      do_reset();
      run_instrs(120, "random");
   endtask

   initial begin
      test_reset();
      test_arith();
      test_cond_jump();
      test_flag_hold();
      test_wrap();
      test_reset_exec();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Instruction sequencer that drives the 4-bit accumulator/ALU datapath, the initiator side of that datapath's control interface.
- Fetches 8-bit instructions from an external program ROM, decodes them, and issues one-cycle control strobes: `accu_en`, `bus1_en`, `bus2_en`, `Sel`, plus the 4-bit operand for `in_bus1`.
- Reads back the datapath `c`/`z` flags for conditional jumps.
- Sits between program ROM and datapath; replaces hand-driven bench stimulus with a small stored-program controller.

## Interface
Parameters:
- `PC_W`, 8, program counter / ROM address width (≥ 5).

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `instr`  in  8  ROM data at `pc`, combinational (async ROM); `[7:4]` opcode, `[3:0]` operand n
- `c`  in  1  datapath carry/borrow, valid combinationally during EXEC
- `z`  in  1  datapath zero flag, valid combinationally during EXEC
- `pc`  out  PC_W  ROM address, registered
- `accu_en`  out  1  accumulator load strobe
- `bus1_en`  out  1  drive operand onto datapath bus 1
- `bus2_en`  out  1  enable datapath output bus
- `Sel`  out  3  ALU op: 000 pass A, 001 A−B, 010 pass B, 011 A+B, 100 NAND
- `oprnd`  out  4  operand to datapath `in_bus1`
- `halted`  out  1  high once HALT executes

## Operation
- FSM states: FETCH → DECODE → EXEC → FETCH. HALT is absorbing and is left only by `reset`.
- FETCH: `ir <= instr`.
- DECODE: `pc <= pc + 1`, modulo 2^PC_W, so 0xFF wraps to 0x00.
- EXEC: control outputs are asserted for exactly this one cycle. Jumps load `pc` here, overriding the DECODE increment.
- Outside EXEC: `accu_en`=`bus1_en`=`bus2_en`=0, `Sel`=000, `oprnd`=0.
- Opcodes, with EXEC outputs:
  - 0x0 NOP: none.
  - 0x1 LDI n: `bus1_en`=1, `accu_en`=1, `Sel`=010, `oprnd`=n.
  - 0x2 ADD n: as LDI with `Sel`=011.
  - 0x3 SUB n: as LDI with `Sel`=001.
  - 0x4 NAND n: as LDI with `Sel`=100.
  - 0x5 OUT: `bus2_en`=1, `Sel`=000.
  - 0x6 JMP n: `pc <= {pc[PC_W-1:4], n}`, a jump within the current 16-word page. The page is taken from the already-incremented `pc`.
  - 0x7 JC / 0x8 JZ / 0x9 JNC / 0xA JNZ n: jump as JMP when the registered flag condition holds, else fall through.
  - 0xF HALT: enter HALT, `halted`=1.
  - 0xB–0xE: treated as NOP.
- Flags:
  - `c_q`, `z_q` are registered on the EXEC clock edge of ADD/SUB/NAND/LDI only, from inputs `c`, `z`.
  - Other opcodes leave the flags unchanged.
  - Conditional jumps test `c_q`/`z_q`, i.e. the flags from the last ALU instruction.
- An ALU instruction immediately followed by a conditional jump sees the new flags: the flag update precedes the jump by ≥ 3 cycles.

## Timing
- Every instruction takes exactly 3 cycles. There are no stalls and no handshake with the ROM: `instr` must be valid in the same cycle `pc` is presented.
- Reset values:
  - state=FETCH, `pc`=0, `ir`=0, `c_q`=`z_q`=0, `halted`=0.
  - All strobes 0, `Sel`=000, `oprnd`=0.
- First FETCH is the cycle after `reset` deasserts. First EXEC strobe is at cycle 3 after reset release.
- `reset` asserted mid-instruction (any state, including EXEC or HALT):
  - Takes effect at that edge and aborts the instruction.
  - No strobe is asserted in the cycle `reset` is high; outputs are gated by `!reset`.
- In HALT: `pc` frozen, all strobes 0, `halted`=1, and `instr` is ignored.
- Simultaneous jump and wrap: the jump target wins, e.g. JMP at 0xFF loads `{0x0, n}`.

## Test plan
- Reset: hold `reset` 2 cycles with random `instr`. Require `pc`=0, all strobes 0, `halted`=0. First `pc` change (0→1) happens on the DECODE edge, 2 cycles after release.
- Arithmetic program:
  - ROM = LDI 1, ADD 3, OUT, HALT (0x11, 0x23, 0x50, 0xF0).
  - EXEC strobes at cycles 3/6/9: `Sel` 010 / 011 / 000 with `oprnd` 1 / 3 / 0.
  - `bus2_en` high only at cycle 9.
  - `halted`=1 after cycle 12, after which `pc` stays 4.
- Conditional jump taken/not taken:
  - ROM = LDI 1, SUB 1 (drive `z`=1), JZ 5, NOP, NOP, HALT.
  - `pc` goes 2 → 3 → 5. Rerun with `z`=0: `pc` goes 3 → 4.
- Flag hold: after ADD with `c`=1, OUT then JC 0x8 is taken.
  - The intervening OUT (with `c` driven 0) must not clear `c_q`.
- Wrap: preload PC region so NOP sits at 0xFF; `pc` wraps to 0x00.
  - JMP 0x3 at 0xFF gives `pc`=0x03.
- Reset during EXEC of ADD: `accu_en` must be 0 that cycle, then the FETCH of address 0 follows.
